// File: rtl/pmem_arbiter.sv
// Purpose: shares one physical-memory port between the I-side (read-only) and D-side (read/write) line requesters, one line at a time, round-robin on ties.
// Latency: request sampled in IDLE at cycle t -> pmem strobe from t+1; pmem_resp at t+k -> requester resp at t+k+1 (minimum 2 cycles).
// Backpressure: requests are held until their resp; only one transaction is outstanding, and the other side waits in IDLE arbitration.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   i_read/i_addr -> i_rdata/i_resp   I-side line read request and completion
//   d_read/d_write/d_addr/d_wdata     D-side line request (write wins if both are set)
//   d_rdata/d_resp                    D-side returned line and completion
//   pmem_read/pmem_write/pmem_addr/pmem_wdata -> pmem_rdata/pmem_resp   physical memory port
module pmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_d;      // last grant went to the D side
    logic              r_owner_d;     // current transaction belongs to the D side
    logic              r_is_write;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_rdata;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant;
    logic              w_grant_d;
    logic              w_capture_rd;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    // Next state, grant decision and strobes/responses. Outputs depend only on
    // registered state, so no requester input reaches pmem combinationally.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_grant_d    = 1'b0;
        w_capture_rd = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_i_req || w_d_req) begin
                    w_grant     = 1'b1;
                    // D wins when alone, or on a tie when I had the last grant.
                    w_grant_d   = w_d_req && (!w_i_req || !r_last_d);
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                pmem_read  = ~r_is_write;
                pmem_write = r_is_write;
                if (pmem_resp) begin
                    w_capture_rd = ~r_is_write;
                    w_state_nxt  = S_RESPOND;
                end
            end
            S_RESPOND: begin
                i_resp      = ~r_owner_d;
                d_resp      = r_owner_d;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_last_d   <= 1'b0;
            r_owner_d  <= 1'b0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner_d  <= w_grant_d;
                r_last_d   <= w_grant_d;
                r_addr     <= w_grant_d ? d_addr : i_addr;
                // d_write wins over d_read, so read+write becomes a write.
                r_is_write <= w_grant_d & d_write;
                if (w_grant_d) begin
                    r_wdata <= d_wdata;
                end
            end
            if (w_capture_rd) begin
                r_rdata <= pmem_rdata;
            end
        end
    end

    assign pmem_addr  = r_addr;
    assign pmem_wdata = r_wdata;
    assign i_rdata    = r_rdata;
    assign d_rdata    = r_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Purpose: self-checking bench for pmem_arbiter: directed vector table, hand sequences, random traffic vs a timeline model.
// Latency: expects strobe one cycle after an IDLE decision and resp lat+2 cycles after the request is first visible.
// Backpressure: bench requesters hold requests until resp and drop them the cycle after.
module tb_pmem_arbiter;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    int n_checks = 0;
    int n_errors = 0;

    // pmem responder controls
    int           pm_lat    = 0;
    logic [127:0] pm_data   = '0;
    bit           pm_use_fn = 1'b0;
    bit           pm_spur   = 1'b0;
    int           pm_cnt    = 0;

    function automatic logic [127:0] rd_fn(input logic [15:0] a);
        return {8{a ^ 16'hC3A5}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // pmem model: answers pm_lat cycles into the strobe; one-cycle resp pulse.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            tick();
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                pm_cnt    = 0;
            end else if (pmem_read || pmem_write) begin
                if (pm_cnt >= pm_lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = pm_use_fn ? rd_fn(pmem_addr) : pm_data;
                end else begin
                    pm_cnt++;
                end
            end else begin
                pm_cnt = 0;
                if (pm_spur) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = {4{32'hBAD0BAD0}};
                    pm_spur    = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit           dside;
        bit           rd;
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
        int           lat;
        bit           exp_wr;
        logic [127:0] exp_rdata;
    } vec_t;

    vec_t tbl[6];

    initial begin
        vec_t         t;
        int           n;
        int           k;
        bit           done;
        bit           re_i;
        bit           re_d;
        bit           acc;
        // random-phase model state; index 0 = I side, 1 = D side
        int           cyc;
        bit           pend[2];
        bit           served[2];
        bit           m_busy;
        int           m_start;
        int           m_resp;
        int           m_free;
        bit           m_own;
        bit           m_wr;
        bit           last_d;
        int           lat;
        logic [15:0]  m_addr;
        logic [127:0] m_wd;
        logic [127:0] m_rdata;
        bit           exp_strobe;

        tbl[0] = '{0, 1, 0, 16'h1230, '0, {16{8'hA5}}, 3, 0, {16{8'hA5}}};
        tbl[1] = '{1, 0, 1, 16'h4440, 128'h0123456789ABCDEF0123456789ABCDEF,
                   {8{16'hDEAD}}, 2, 1, {16{8'hA5}}};
        tbl[2] = '{1, 1, 0, 16'h8880, '0, {16{8'h3C}}, 0, 0, {16{8'h3C}}};
        tbl[3] = '{1, 1, 1, 16'h0010, {8{16'hFF00}}, {8{16'hDEAD}}, 1, 1, {16{8'h3C}}};
        tbl[4] = '{0, 1, 0, 16'hFFF0, '0, {8{16'h1111}}, 5, 0, {8{16'h1111}}};
        tbl[5] = '{1, 0, 1, 16'h0000, {128{1'b1}}, {8{16'hDEAD}}, 0, 1, {8{16'h1111}}};

        // ---------------- reset state ----------------
        reset_n = 1'b0;
        i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        #1;
        chk("reset strobes_resps", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0);
        chk("reset pmem_addr", pmem_addr, 16'h0);
        chk("reset pmem_wdata", pmem_wdata, 128'h0);
        chk("reset rdata", i_rdata | d_rdata, 128'h0);
        do_reset();

        // ---------------- directed vector table ----------------
        for (int v = 0; v < 6; v++) begin
            t = tbl[v];
            pm_lat = t.lat; pm_data = t.rdata; pm_use_fn = 1'b0;
            if (t.dside) begin
                d_read = t.rd; d_write = t.wr; d_addr = t.addr; d_wdata = t.wdata;
            end else begin
                i_read = 1'b1; i_addr = t.addr;
            end
            n = 0; done = 1'b0;
            while (!done && n < 40) begin
                tick();
                n++;
                chk($sformatf("vec%0d strobe c%0d", v, n), pmem_read | pmem_write, (n <= t.lat + 1));
                if (n == 1) begin
                    chk($sformatf("vec%0d pmem_write", v), pmem_write, t.exp_wr);
                    chk($sformatf("vec%0d pmem_addr", v), pmem_addr, t.addr);
                    if (t.exp_wr) chk($sformatf("vec%0d pmem_wdata", v), pmem_wdata, t.wdata);
                    // inputs change while BUSY: must not be resampled
                    i_addr = ~t.addr; d_addr = ~t.addr; d_wdata = ~t.wdata;
                end
                if (i_resp || d_resp) begin
                    done = 1'b1;
                    chk($sformatf("vec%0d latency", v), n, t.lat + 2);
                    chk($sformatf("vec%0d resp side", v), {i_resp, d_resp}, {!t.dside, t.dside});
                    chk($sformatf("vec%0d rdata", v), t.dside ? d_rdata : i_rdata, t.exp_rdata);
                    chk($sformatf("vec%0d addr held", v), pmem_addr, t.addr);
                    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
                    tick();
                    chk($sformatf("vec%0d resp one cycle", v), i_resp | d_resp, 1'b0);
                end
            end
            if (!done) chk($sformatf("vec%0d resp timeout", v), 1'b0, 1'b1);
        end

        // ---------------- pmem_resp outside BUSY ignored ----------------
        pm_spur = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            acc = acc | i_resp | d_resp | pmem_read | pmem_write;
        end
        chk("spurious resp activity", acc, 1'b0);
        chk("spurious resp rdata", i_rdata, {8{16'h1111}});

        // ---------------- ties after reset / starvation ----------------
        do_reset();
        pm_use_fn = 1'b1; pm_lat = 1;
        i_addr = 16'h1000; d_addr = 16'h2000;
        i_read = 1'b1; d_read = 1'b1;
        k = 0; n = 0; re_i = 1'b0; re_d = 1'b0;
        while (k < 6 && n < 200) begin
            tick();
            n++;
            if (re_i) begin i_read = 1'b1; re_i = 1'b0; end
            if (re_d) begin d_read = 1'b1; re_d = 1'b0; end
            if (i_resp || d_resp) begin
                chk($sformatf("tie grant%0d is D", k), d_resp, (k % 2 == 0));
                chk($sformatf("tie grant%0d data", k), d_resp ? d_rdata : i_rdata,
                    rd_fn(d_resp ? 16'h2000 : 16'h1000));
                if (d_resp) begin d_read = 1'b0; re_d = 1'b1; end
                else begin i_read = 1'b0; re_i = 1'b1; end
                k++;
            end
        end
        chk("tie grants completed", k, 6);
        i_read = 1'b0; d_read = 1'b0;
        tick(); tick(); tick(); tick();

        // ---------------- reset during BUSY ----------------
        pm_use_fn = 1'b0; pm_lat = 30; pm_data = {8{16'h7777}};
        d_read = 1'b1; d_addr = 16'h7770;
        tick(); tick();
        chk("rst pre pmem_read", pmem_read, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst async pmem_read", {pmem_read, pmem_write}, 2'b0);
        d_read = 1'b0;
        acc = 1'b0;
        tick(); acc = acc | d_resp;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            acc = acc | d_resp | i_resp | pmem_read | pmem_write;
        end
        chk("rst no resp after abort", acc, 1'b0);
        pm_use_fn = 1'b1; pm_lat = 2;
        i_read = 1'b1; i_addr = 16'h3330;
        n = 0; done = 1'b0;
        while (!done && n < 20) begin
            tick();
            n++;
            if (n == 1) chk("rst regrant addr", {pmem_read, pmem_addr}, {1'b1, 16'h3330});
            if (i_resp || d_resp) begin
                done = 1'b1;
                chk("rst regrant latency", n, 4);
                chk("rst regrant side", {i_resp, d_resp}, 2'b10);
                chk("rst regrant data", i_rdata, rd_fn(16'h3330));
                i_read = 1'b0;
            end
        end
        if (!done) chk("rst regrant timeout", 1'b0, 1'b1);

        // ---------------- random traffic vs timeline model ----------------
        do_reset();
        pm_use_fn = 1'b1;
        pend[0] = 0; pend[1] = 0;
        m_busy = 0; m_start = 0; m_resp = 0; m_free = 0; m_own = 0; m_wr = 0;
        last_d = 0; m_addr = '0; m_wd = '0; m_rdata = '0;
        cyc = 0;
        for (int it = 0; it < 2000; it++) begin
            tick();
            cyc++;
            served[0] = 0; served[1] = 0;
            exp_strobe = m_busy && (cyc >= m_start + 1) && (cyc <= m_resp - 1);
            chk("rnd strobe", pmem_read | pmem_write, exp_strobe);
            if (exp_strobe) begin
                chk("rnd pmem_addr", pmem_addr, m_addr);
                chk("rnd pmem_write", {pmem_write, pmem_read}, {m_wr, !m_wr});
                if (m_wr) chk("rnd pmem_wdata", pmem_wdata, m_wd);
            end
            chk("rnd i_resp", i_resp, m_busy && cyc == m_resp && !m_own);
            chk("rnd d_resp", d_resp, m_busy && cyc == m_resp && m_own);
            if (m_busy && cyc == m_resp) begin
                if (!m_wr) m_rdata = rd_fn(m_addr);
                chk("rnd rdata", {i_rdata, d_rdata}, {m_rdata, m_rdata});
                pend[m_own] = 0;
                served[m_own] = 1;
                m_busy = 0;
                m_free = cyc + 1;
                if (m_own) begin d_read = 0; d_write = 0; end
                else i_read = 0;
            end
            // requesters
            if (!pend[0] && !served[0] && it < 1800 && $urandom_range(0, 3) == 0) begin
                pend[0] = 1; i_read = 1; i_addr = 16'($urandom);
            end
            if (!pend[1] && !served[1] && it < 1800 && $urandom_range(0, 3) == 0) begin
                pend[1] = 1; d_addr = 16'($urandom); d_wdata = {$urandom, $urandom, $urandom, $urandom};
                case ($urandom_range(0, 6))
                    0, 1, 2: begin d_read = 1; d_write = 0; end
                    3, 4, 5: begin d_read = 0; d_write = 1; end
                    default: begin d_read = 1; d_write = 1; end
                endcase
            end
            // arbitration: decided in the first free cycle with a visible request
            if (!m_busy && cyc >= m_free && (pend[0] || pend[1])) begin
                m_own   = pend[1] && (!pend[0] || !last_d);
                last_d  = m_own;
                lat     = $urandom_range(0, 4);
                pm_lat  = lat;
                m_busy  = 1;
                m_start = cyc;
                m_resp  = cyc + lat + 2;
                m_addr  = m_own ? d_addr : i_addr;
                m_wr    = m_own && d_write;
                m_wd    = d_wdata;
            end
        end
        chk("rnd drained", {pend[0], pend[1], m_busy}, 3'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between the instruction-side cache (read-only) and the data-side cache/victim-cache path (read and write).
- Sits between the L1 cache controllers and physical memory.
- Grants one line transaction at a time, with round-robin fairness on ties.
- Registers address, write data and read data so that neither requester's combinational paths reach pmem.

Parameters:
ADDR_W, 16, byte address width of requester and pmem addresses
LINE_W, 128, cache line width in bits (8 x 16-bit words)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
i_read  input  1  I-side line read request, held until i_resp
i_addr  input  ADDR_W  I-side line address
i_rdata  output  LINE_W  I-side returned line
i_resp  output  1  I-side completion pulse, one cycle
d_read  input  1  D-side line read request, held until d_resp
d_write  input  1  D-side line write request, held until d_resp
d_addr  input  ADDR_W  D-side line address
d_wdata  input  LINE_W  D-side write line
d_rdata  output  LINE_W  D-side returned line
d_resp  output  1  D-side completion pulse, one cycle
pmem_read  output  1  pmem read strobe, held until pmem_resp
pmem_write  output  1  pmem write strobe, held until pmem_resp
pmem_addr  output  ADDR_W  pmem address (registered)
pmem_wdata  output  LINE_W  pmem write line (registered)
pmem_rdata  input  LINE_W  pmem read line, valid with pmem_resp
pmem_resp  input  1  pmem completion

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, last_grant=I, addr_reg=0, wdata_reg=0, rdata_reg=0, is_write=0, owner=I.
  - All outputs 0.
- States:
  - IDLE: pmem strobes low, no resp.
    - Evaluate requests; I request = i_read; D request = d_read|d_write.
    - If only one requests, grant it. If both request, grant the side not equal to last_grant.
    - On grant at the edge: capture the owner's addr into addr_reg; capture d_wdata into wdata_reg if D; set is_write=d_write for D, else 0; set owner and last_grant; go to BUSY.
    - With no request, stay in IDLE.
  - BUSY:
    - pmem_read=~is_write, pmem_write=is_write, pmem_addr=addr_reg, pmem_wdata=wdata_reg.
    - Requester inputs are ignored (not resampled).
    - On pmem_resp: if ~is_write, capture pmem_rdata into rdata_reg; go to RESPOND. Otherwise stay in BUSY.
  - RESPOND: pmem strobes low; assert i_resp if owner=I, else d_resp, for exactly one cycle; next state IDLE unconditionally.
- i_rdata and d_rdata both drive rdata_reg continuously. rdata_reg is unchanged by writes.
- Latency:
  - A request seen in IDLE at cycle t gives a pmem strobe from t+1.
  - pmem_resp at cycle t+k (k>=1) gives the requester's resp at t+k+1.
  - Minimum request-to-resp latency is 2 cycles.
- Requesters drop their request in the cycle after resp. The arbiter re-evaluates in IDLE only, so a dropped request is never re-granted.
- Back-to-back: a side that requests again while the other is waiting loses the tie (round-robin), so neither side starves.
- d_read and d_write both high: treated as a write (is_write=1). This is illegal stimulus but must be deterministic.
- pmem_resp outside BUSY is ignored.
- Request deasserted while in BUSY: the transaction still completes and resp is still pulsed.
- Reset mid-transaction: immediate return to IDLE with strobes low. The pending pmem access is abandoned and no resp is issued.

Test Plan:
- Single I read: i_read=1, i_addr=0x1230; pmem_resp 3 cycles after pmem_read rises with pmem_rdata=0xA5..A5 -> pmem_addr=0x1230, pmem_write=0; i_resp pulses one cycle after pmem_resp; i_rdata=0xA5..A5; d_resp stays 0.
- D write: d_write=1, d_addr=0x4440, d_wdata=0x0123..CDEF -> pmem_write=1 with registered data until pmem_resp; d_resp one cycle later; rdata_reg unchanged.
- Simultaneous after reset: i_read and d_read both high -> D granted first (last_grant=I at reset); after d_resp, I granted; second tie with both re-requesting -> D granted.
- Starvation check: D requests continuously while I holds i_read -> grants alternate D, I, D, I; max one D transaction between I grants.
- Zero-wait pmem: pmem_resp high in the first BUSY cycle -> resp exactly 2 cycles after the request was sampled in IDLE.
- Reset mid-BUSY: drop reset_n during a D read -> pmem_read falls asynchronously, no d_resp; after release, state is IDLE and a new i_read is granted normally.
